linear_layer_mac: RTL and testbench



---
 rtl/linear_pkg.sv | 58 +++++
 rtl/linear_layer_mac_lanes.sv | 48 ++++
 rtl/linear_layer_mac.sv | 165 ++++++++++++++++
 tb/tb_linear_layer_mac.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_pkg.sv
// linear_pkg: FSM states, rounding modes and the fixed-point
// shift/bias/saturate helper shared by the fully connected layer.
package linear_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Working widths of the helper; the layer keeps its own
  // accumulator and data widths within these.
  localparam int SR_ACC_W = 64;
  localparam int SR_VAL_W = 32;

  typedef struct packed {
    logic signed [SR_VAL_W-1:0] value;
    logic                       sat;
  } sat_t;

  // Scale the accumulator down by fb bits, add the bias and clamp
  // to a dw-bit signed range. The bias arrives sign-extended.
  function automatic sat_t sat_round(
    input logic signed [SR_ACC_W-1:0] acc,
    input logic signed [SR_ACC_W-1:0] bias,
    input int unsigned                dw,
    input int unsigned                fb,
    input logic                       half_up
  );
    logic signed [SR_ACC_W-1:0] one;
    logic signed [SR_ACC_W-1:0] t;
    logic signed [SR_ACC_W-1:0] hi;
    logic signed [SR_ACC_W-1:0] lo;
    sat_t                       r;
    one = 1;
    t   = acc;
    if (half_up) begin
      t = t + (one <<< (fb - 1));
    end
    t  = (t >>> fb) + bias;
    hi = (one <<< (dw - 1)) - one;
    lo = -(one <<< (dw - 1));
    r.sat = 1'b0;
    if (t > hi) begin
      t     = hi;
      r.sat = 1'b1;
    end else if (t < lo) begin
      t     = lo;
      r.sat = 1'b1;
    end
    r.value = SR_VAL_W'(t);
    return r;
  endfunction

endpackage

// File: rtl/linear_layer_mac_lanes.sv
// linear_mac_lanes: LANES signed multipliers and an adder tree
// for one beat of the dot product; pad slots contribute zero.
module linear_mac_lanes #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 2,
  parameter int BEATS      = 2,
  parameter int BEAT_W     = 1,
  parameter int ACC_W      = 35
) (
  input  logic [BEAT_W-1:0]                     beat_i,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] x_i,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] w_i,
  output logic signed [ACC_W-1:0]               sum_o
);

  localparam int PAD   = BEATS * LANES;
  localparam int PW    = (PAD > 1) ? $clog2(PAD) : 1;
  localparam int EXT_W = ACC_W - 2 * DATA_WIDTH;

  logic [PAD-1:0][DATA_WIDTH-1:0] xp;
  logic [PAD-1:0][DATA_WIDTH-1:0] wp;

  // Pad both vectors to whole beats; slots past NUM_INPUTS stay 0.
  always_comb begin
    xp = '0;
    wp = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      xp[i] = x_i[i];
      wp[i] = w_i[i];
    end
  end

  // Multiply each lane of the current beat and sum at full width.
  always_comb begin
    logic [PW-1:0]                 k;
    logic signed [2*DATA_WIDTH-1:0] p;
    k     = '0;
    p     = '0;
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      k     = PW'(beat_i) * PW'(LANES) + PW'(l);
      p     = $signed(xp[k]) * $signed(wp[k]);
      sum_o = sum_o + {{EXT_W{p[2*DATA_WIDTH-1]}}, p};
    end
  end

endmodule

// File: rtl/linear_layer_mac.sv
// linear_layer_mac: streaming W*x+b layer, LANES MACs per cycle,
// one neuron per output handshake with saturation flag.
module linear_layer_mac
  import linear_pkg::*;
#(
  parameter int NUM_INPUTS   = 4,
  parameter int NUM_OUTPUTS  = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 13,
  parameter int LANES        = 2,
  parameter int ROUND_MODE   = 0,
  parameter int RELU_EN      = 0,
  parameter     WEIGHTS_FILE = "weights.mem",
  parameter     BIAS_FILE    = "bias.mem"
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [DATA_WIDTH-1:0]          output_current,
  output logic [$clog2(NUM_OUTPUTS)-1:0]        output_idx,
  output logic                                  out_sat,
  output logic                                  out_last,
  output logic                                  busy
);

  localparam int BEATS = (NUM_INPUTS + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW    = $clog2(NUM_OUTPUTS);
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NUM_INPUTS + 1);
  localparam int WAW   = $clog2(NUM_OUTPUTS * NUM_INPUTS);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [NW-1:0] NRN_LAST  = NW'(NUM_OUTPUTS - 1);

  logic signed [DATA_WIDTH-1:0] w_rom [NUM_OUTPUTS*NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] b_rom [NUM_OUTPUTS];

  state_t                               state_q;
  logic [NW-1:0]                        neuron_q;
  logic [BW-1:0]                        beat_q;
  logic signed [ACC_W-1:0]              acc_q;
  logic signed [ACC_W-1:0]              acc_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] x_q;
  logic                                 in_ready_q;
  logic                                 out_valid_q;
  logic signed [DATA_WIDTH-1:0]         out_cur_q;
  logic [NW-1:0]                        out_idx_q;
  logic                                 out_sat_q;
  logic                                 out_last_q;
  logic                                 busy_q;

  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] w_row;
  logic signed [ACC_W-1:0]              lane_sum;
  sat_t                                 sr;
  logic signed [DATA_WIDTH-1:0]         res_v;

  always_comb begin
    logic [WAW-1:0] base;
    base  = WAW'(neuron_q) * WAW'(NUM_INPUTS);
    w_row = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_row[i] = w_rom[base + WAW'(i)];
    end
  end

  linear_mac_lanes #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .BEATS      (BEATS),
    .BEAT_W     (BW),
    .ACC_W      (ACC_W)
  ) u_lanes (
    .beat_i (beat_q),
    .x_i    (x_q),
    .w_i    (w_row),
    .sum_o  (lane_sum)
  );

  always_comb begin
    acc_d = acc_q + lane_sum;
    sr    = sat_round(SR_ACC_W'(acc_d),
                      SR_ACC_W'(b_rom[neuron_q]),
                      DATA_WIDTH, FRAC_BITS,
                      ROUND_MODE == ROUND_HALF_UP);
    res_v = sr.value[DATA_WIDTH-1:0];
    if (RELU_EN != 0 && res_v[DATA_WIDTH-1]) begin
      res_v = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      neuron_q    <= '0;
      beat_q      <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cur_q   <= '0;
      out_idx_q   <= '0;
      out_sat_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= inputs;
            neuron_q   <= '0;
            beat_q     <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (beat_q == BEAT_LAST) begin
            out_cur_q  <= res_v;
            out_idx_q  <= neuron_q;
            out_sat_q  <= sr.sat;
            out_last_q <= (neuron_q == NRN_LAST);
            state_q    <= EMIT;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        EMIT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            beat_q      <= '0;
            if (out_last_q) begin
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              neuron_q <= neuron_q + NW'(1);
              state_q  <= ACCUM;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign output_current = out_cur_q;
  assign output_idx     = out_idx_q;
  assign out_sat        = out_sat_q;
  assign out_last       = out_last_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_linear_layer_mac.sv
// tb_linear_layer_mac: directed vectors on a truncating and a
// rounding+ReLU instance driven in lockstep.
module tb_linear_layer_mac;

  localparam int NI = 4;
  localparam int NO = 16;
  localparam int DW = 16;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   out_ready = 1'b1;
  logic [NI-1:0][DW-1:0]  inputs = '0;

  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_sat   [2];
  logic          out_last  [2];
  logic          busy      [2];
  logic [DW-1:0] ocur      [2];
  logic [3:0]    oidx      [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  linear_layer_mac #(
    .ROUND_MODE   (0),
    .RELU_EN      (0),
    .WEIGHTS_FILE (""),
    .BIAS_FILE    ("")
  ) u_d0 (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready[0]),
    .inputs         (inputs),
    .out_valid      (out_valid[0]),
    .out_ready      (out_ready),
    .output_current (ocur[0]),
    .output_idx     (oidx[0]),
    .out_sat        (out_sat[0]),
    .out_last       (out_last[0]),
    .busy           (busy[0])
  );

  linear_layer_mac #(
    .ROUND_MODE   (1),
    .RELU_EN      (1),
    .WEIGHTS_FILE (""),
    .BIAS_FILE    ("")
  ) u_d1 (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready[1]),
    .inputs         (inputs),
    .out_valid      (out_valid[1]),
    .out_ready      (out_ready),
    .output_current (ocur[1]),
    .output_idx     (oidx[1]),
    .out_sat        (out_sat[1]),
    .out_last       (out_last[1]),
    .busy           (busy[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wval(input int n);
    case (n)
      0:       return 16'h1000;
      1:       return 16'h6000;
      2:       return 16'hA000;
      default: return 16'(n * 256);
    endcase
  endfunction

  function automatic logic [DW-1:0] bval(input int n);
    case (n)
      0, 1, 2: return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'(n);
    endcase
  endfunction

  // {sat, value}; vid 0: x all 0x2000, vid 1: x0 = 1, rest 0
  function automatic logic [16:0] expv(input int vid,
                                       input int d,
                                       input int n);
    if (vid == 0) begin
      case (n)
        0:       return 17'h04000;
        1:       return 17'h17FFF;
        2:       return (d == 1) ? 17'h10000 : 17'h18000;
        3:       return 17'h00BFF;
        default: return 17'(n * 32'h401);
      endcase
    end
    case (n)
      0:       return (d == 1) ? 17'h00001 : 17'h00000;
      1:       return 17'h00003;
      2:       return (d == 1) ? 17'h00000 : 17'h0FFFD;
      3:       return (d == 1) ? 17'h00000 : 17'h0FFFF;
      default: return 17'(n);
    endcase
  endfunction

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_rdy%0d", tag, d), 32'(in_ready[d]), 1);
      check($sformatf("%s_vld%0d", tag, d), 32'(out_valid[d]), 0);
      check($sformatf("%s_cur%0d", tag, d), 32'(ocur[d]), 0);
      check($sformatf("%s_idx%0d", tag, d), 32'(oidx[d]), 0);
      check($sformatf("%s_sat%0d", tag, d), 32'(out_sat[d]), 0);
      check($sformatf("%s_lst%0d", tag, d), 32'(out_last[d]), 0);
      check($sformatf("%s_bsy%0d", tag, d), 32'(busy[d]), 0);
    end
  endtask

  // Called on a negedge; returns on a negedge.
  task automatic run_vec(input logic [63:0] x,
                         input int vid,
                         input int hold_n,
                         input int abort_n,
                         input int pulse_n);
    int            cyc;
    logic [16:0]   e;
    logic [DW-1:0] cur0;
    logic [3:0]    idx0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("v%0d_idle_rdy%0d", vid, d), 32'(in_ready[d]), 1);
      check($sformatf("v%0d_idle_bsy%0d", vid, d), 32'(busy[d]), 0);
    end
    inputs   = x;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inputs   = ~x;
    check($sformatf("v%0d_busy", vid), 32'(busy[0]), 1);
    check($sformatf("v%0d_nrdy", vid), 32'(in_ready[0]), 0);
    for (int n = 0; n < NO; n++) begin
      cyc = 0;
      if (n == abort_n) begin
        check($sformatf("v%0d_pre_rst_bsy", vid), 32'(busy[0]), 1);
        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (n == pulse_n) begin
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        check($sformatf("v%0d_pulse_rdy", vid), 32'(in_ready[0]), 0);
      end
      while (out_valid[0] !== 1'b1 && cyc < 20) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      check($sformatf("v%0d_lat_n%0d", vid, n), cyc, 3);
      if (cyc >= 20) return;
      if (n == hold_n) begin
        out_ready = 1'b0;
        cur0 = ocur[0];
        idx0 = oidx[0];
        repeat (5) begin
          @(posedge clk);
          @(negedge clk);
          check("hold_vld", 32'(out_valid[0]), 1);
          check("hold_cur", 32'(ocur[0]), 32'(cur0));
          check("hold_idx", 32'(oidx[0]), 32'(idx0));
          check("hold_rdy", 32'(in_ready[0]), 0);
        end
        out_ready = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
        e = expv(vid, d, n);
        check($sformatf("v%0d_d%0d_vld_n%0d", vid, d, n),
              32'(out_valid[d]), 1);
        check($sformatf("v%0d_d%0d_idx_n%0d", vid, d, n),
              32'(oidx[d]), n);
        check($sformatf("v%0d_d%0d_cur_n%0d", vid, d, n),
              32'(ocur[d]), 32'(e[15:0]));
        check($sformatf("v%0d_d%0d_sat_n%0d", vid, d, n),
              32'(out_sat[d]), 32'(e[16]));
        check($sformatf("v%0d_d%0d_lst_n%0d", vid, d, n),
              32'(out_last[d]), (n == NO - 1) ? 1 : 0);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int n = 0; n < NO; n++) begin
      for (int i = 0; i < NI; i++) begin
        u_d0.w_rom[n*NI+i] = wval(n);
        u_d1.w_rom[n*NI+i] = wval(n);
      end
      u_d0.b_rom[n] = bval(n);
      u_d1.b_rom[n] = bval(n);
    end
    repeat (3) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    @(negedge clk);
    run_vec({4{16'h2000}}, 0, 3, -1, 2);
    run_vec(64'h0000_0000_0000_0001, 1, -1, -1, -1);
    run_vec({4{16'h2000}}, 0, -1, 7, -1);
    run_vec(64'h0000_0000_0000_0001, 1, -1, -1, -1);
    run_vec({4{16'h2000}}, 0, -1, -1, -1);
    check("end_rdy", 32'(in_ready[0]), 1);
    check("end_bsy", 32'(busy[0]), 0);
    check("end_vld", 32'(out_valid[0]), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
